gray_counter_n: RTL and testbench

- Parametrised up/down Gray-code counter with an integrated prescaler.
- The counter steps once every PRESCALE enabled clock cycles. Outputs are the registered Gray code, the matching binary count, and one-cycle status pulses.
- Supports synchronous load of a Gray value and a choice of wrap or saturate at the range ends.
- Drives board LEDs or other slow indicators, and serves as a reusable phase/position counter elsewhere in the design.

---
 rtl/gray_counter_n.sv | 57 +++++
 tb/tb_gray_counter_n.sv | 95 +++++++++
 2 files changed

// File: rtl/gray_counter_n.sv
// gray_counter_n: prescaled up/down Gray counter with load, wrap/saturate and step/wrap pulses
module gray_counter_n #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 10000000,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_code,
  output logic [WIDTH-1:0] bin_code,
  output logic             step,
  output logic             wrap
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam bit SAT = SATURATE != 0;
  logic [PW-1:0] pcnt;
  logic [WIDTH-1:0] lb, nb;
  logic tick, at_end, hold;
  for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
    assign lb[i] = ^load_gray[WIDTH-1:i];
  end
  assign tick   = en & (pcnt == PMAX);
  assign at_end = up_down ? &bin_code : ~|bin_code;
  assign hold   = SAT & at_end;
  assign nb     = up_down ? bin_code + 1'b1 : bin_code - 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt      <= '0;
      bin_code  <= '0;
      gray_code <= '0;
      step      <= 1'b0;
      wrap      <= 1'b0;
    end else if (load) begin
      pcnt      <= '0;
      bin_code  <= lb;
      gray_code <= load_gray;
      step      <= 1'b0;
      wrap      <= 1'b0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      step <= tick & ~hold;
      wrap <= tick & at_end;
      if (tick && !hold) begin
        bin_code  <= nb;
        gray_code <= nb ^ (nb >> 1);
      end
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gray_counter_n.sv
// tb_gray_counter_n: directed checks of a wrapping and a saturating gray_counter_n (WIDTH=4, PRESCALE=3)
module tb_gray_counter_n;
  logic clk = 0, rst_n = 0, en = 0, up_down = 1, load = 0;
  logic [3:0] load_gray = '0;
  logic [3:0] g0, b0, g1, b1;
  logic s0, w0, s1, w1;
  int n_cmp = 0, n_err = 0;
  logic [3:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  always #5 clk = ~clk;
  gray_counter_n #(.WIDTH(4), .PRESCALE(3), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .load(load), .load_gray(load_gray),
    .gray_code(g0), .bin_code(b0), .step(s0), .wrap(w0));
  gray_counter_n #(.WIDTH(4), .PRESCALE(3), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .load(load), .load_gray(load_gray),
    .gray_code(g1), .bin_code(b1), .step(s1), .wrap(w1));
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_w(input string tag, input logic [3:0] b, input logic [3:0] g, input logic s, input logic w);
    check({tag, ".w.bin"}, 16'(b0), 16'(b));
    check({tag, ".w.gray"}, 16'(g0), 16'(g));
    check({tag, ".w.step"}, 16'(s0), 16'(s));
    check({tag, ".w.wrap"}, 16'(w0), 16'(w));
  endtask
  task automatic chk_s(input string tag, input logic [3:0] b, input logic [3:0] g, input logic s, input logic w);
    check({tag, ".s.bin"}, 16'(b1), 16'(b));
    check({tag, ".s.gray"}, 16'(g1), 16'(g));
    check({tag, ".s.step"}, 16'(s1), 16'(s));
    check({tag, ".s.wrap"}, 16'(w1), 16'(w));
  endtask
  initial begin
    cyc();
    chk_w("reset", 4'h0, 4'h0, 0, 0);
    chk_s("reset", 4'h0, 4'h0, 0, 0);
    rst_n = 1; en = 1; up_down = 1;
    for (int k = 1; k <= 16; k++) begin
      cyc(2);
      check("up.idle", 16'({s0, w0, s1, w1}), 16'h0);
      cyc();
      chk_w("up", 4'(k), gseq[k % 16], 1, k == 16);
      if (k < 16) chk_s("up", 4'(k), gseq[k], 1, 0);
      else chk_s("sat_hi", 4'hF, 4'h8, 0, 1);
    end
    up_down = 0;
    cyc(3);
    chk_w("dn1", 4'hF, 4'h8, 1, 1);
    chk_s("dn1", 4'hE, 4'h9, 1, 0);
    cyc(3);
    chk_w("dn2", 4'hE, 4'h9, 1, 0);
    chk_s("dn2", 4'hD, 4'hB, 1, 0);
    cyc();
    load = 1; load_gray = 4'b1010;
    cyc();
    load = 0; up_down = 1;
    chk_w("load", 4'hC, 4'hA, 0, 0);
    chk_s("load", 4'hC, 4'hA, 0, 0);
    cyc(2);
    check("load.idle", 16'({s0, s1}), 16'h0);
    cyc();
    chk_w("load.step", 4'hD, 4'hB, 1, 0);
    cyc();
    en = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_w("frozen", 4'hD, 4'hB, 0, 0);
    end
    en = 1;
    cyc();
    check("resume.idle", 16'(s0), 16'h0);
    cyc();
    chk_w("resume", 4'hE, 4'h9, 1, 0);
    chk_s("resume", 4'hE, 4'h9, 1, 0);
    cyc(2);
    rst_n = 0; load = 1; load_gray = 4'hF;
    cyc();
    rst_n = 1; load = 0;
    chk_w("rst_mid", 4'h0, 4'h0, 0, 0);
    chk_s("rst_mid", 4'h0, 4'h0, 0, 0);
    cyc(2);
    check("rst.idle", 16'(s0), 16'h0);
    cyc();
    chk_w("rst.step", 4'h1, 4'h1, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
